park_decrypt_ctrl: RTL and testbench

PARK_DECRYPT_CTRL -- requirements
Module: park_decrypt_ctrl

---
 rtl/park_decrypt_ctrl_if.sv | 32 +++
 rtl/park_decrypt_ctrl.sv | 171 +++++++++++++++++
 tb/tb_park_decrypt_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/park_decrypt_ctrl_if.sv
// Request/response bus for the parking decrypt controller.
//
// Handshake rules, both channels: the producer raises valid and keeps valid
// and its payload stable until it sees ready=1 on a rising clk edge. The
// transfer happens on exactly that edge. The consumer may drive ready
// independently of valid. On the request channel the controller is the
// consumer (in_ready). On the response channel it is the producer (out_valid).
interface park_decrypt_ctrl_if #(
  parameter int SLOT_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic              exit;
  logic [SLOT_W-1:0] token;
  logic [SLOT_W-1:0] pattern;
  logic              out_valid;
  logic              out_ready;
  logic [SLOT_W-1:0] park_number;
  logic [1:0]        status;

  // Requester / response consumer side
  modport master (
    output in_valid, exit, token, pattern, out_ready,
    input  in_ready, out_valid, park_number, status
  );

  // Controller side
  modport slave (
    input  in_valid, exit, token, pattern, out_ready,
    output in_ready, out_valid, park_number, status
  );
endinterface

// File: rtl/park_decrypt_ctrl.sv
// Parking-lot slot controller: it decrypts the slot number (token XOR
// pattern) and records entries and exits in an occupancy map. It counts
// consecutive failed requests. When that count reaches MAX_FAIL, it blocks
// new requests for LOCK_CYC cycles after the failing response is taken.
module park_decrypt_ctrl #(
  parameter int SLOT_W   = 3,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  park_decrypt_ctrl_if.slave      bus,
  output logic [(1<<SLOT_W)-1:0]  occupancy,
  output logic [SLOT_W:0]         free_count,
  output logic                    locked,
  output logic [1:0]              dbg_state
);
  localparam int N_SLOTS = 1 << SLOT_W;
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int LOCK_W  = $clog2(LOCK_CYC + 1);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_EMPTY = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2,
    S_LOCK = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [SLOT_W-1:0]   park_number_q, park_number_d;
  logic [1:0]          status_q, status_d;
  logic [N_SLOTS-1:0]  occupancy_q, occupancy_d;
  logic [SLOT_W:0]     free_count_q, free_count_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                locked_q, locked_d;
  logic                req_exit_q, req_exit_d;
  logic [SLOT_W-1:0]   req_slot_q, req_slot_d;

  // Next-state logic: request capture, slot evaluation, response hold, lockout timer
  always_comb begin
    int unsigned ones;
    logic        failed;
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    park_number_d = park_number_q;
    status_d      = status_q;
    occupancy_d   = occupancy_q;
    fail_d        = fail_q;
    lock_cnt_d    = lock_cnt_q;
    locked_d      = locked_q;
    req_exit_d    = req_exit_q;
    req_slot_d    = req_slot_q;
    failed        = 1'b0;
    ones          = 0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          req_exit_d = bus.exit;
          req_slot_d = bus.token ^ bus.pattern;
          state_d    = S_EVAL;
        end
      end
      S_EVAL: begin
        park_number_d = req_slot_q;
        status_d      = ST_OK;
        if (!req_exit_q) begin
          if (occupancy_q[req_slot_q]) begin
            status_d = ST_BUSY;
            failed   = 1'b1;
          end else begin
            occupancy_d[req_slot_q] = 1'b1;
          end
        end else begin
          if (occupancy_q[req_slot_q]) begin
            occupancy_d[req_slot_q] = 1'b0;
          end else begin
            status_d = ST_EMPTY;
            failed   = 1'b1;
          end
        end
        // The failure count stops at MAX_FAIL so that the RESP exit check sees an exact match.
        if (!failed) begin
          fail_d = '0;
        end else if (fail_q != FAIL_W'(MAX_FAIL)) begin
          fail_d = fail_q + 1'b1;
        end
        out_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (fail_q == FAIL_W'(MAX_FAIL)) begin
            fail_d     = '0;
            lock_cnt_d = LOCK_W'(LOCK_CYC);
            locked_d   = 1'b1;
            state_d    = S_LOCK;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LOCK: begin
        // The counter is loaded with LOCK_CYC. The state leaves LOCK on the edge where the counter reads 1.
        if (lock_cnt_q <= LOCK_W'(1)) begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);

    for (int i = 0; i < N_SLOTS; i++) begin
      ones = ones + 32'(occupancy_d[i]);
    end
    free_count_d = (SLOT_W+1)'(N_SLOTS - int'(ones));
  end

  // State and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      park_number_q <= '0;
      status_q      <= ST_OK;
      occupancy_q   <= '0;
      free_count_q  <= (SLOT_W+1)'(N_SLOTS);
      fail_q        <= '0;
      lock_cnt_q    <= '0;
      locked_q      <= 1'b0;
      req_exit_q    <= 1'b0;
      req_slot_q    <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      park_number_q <= park_number_d;
      status_q      <= status_d;
      occupancy_q   <= occupancy_d;
      free_count_q  <= free_count_d;
      fail_q        <= fail_d;
      lock_cnt_q    <= lock_cnt_d;
      locked_q      <= locked_d;
      req_exit_q    <= req_exit_d;
      req_slot_q    <= req_slot_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.park_number = park_number_q;
  assign bus.status      = status_q;
  assign occupancy       = occupancy_q;
  assign free_count      = free_count_q;
  assign locked          = locked_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_park_decrypt_ctrl.sv
// Bench for park_decrypt_ctrl.
// Directed requests push their expected responses into a queue.
// A monitor pops one entry for each response the DUT presents and compares it.
module tb_park_decrypt_ctrl;
  localparam int SLOT_W   = 3;
  localparam int N        = 1 << SLOT_W;
  localparam int MAX_FAIL = 3;
  localparam int LOCK_CYC = 16;
  localparam int EW       = SLOT_W + 2 + N + SLOT_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  park_decrypt_ctrl_if #(.SLOT_W(SLOT_W)) bus ();
  logic [N-1:0]    occupancy;
  logic [SLOT_W:0] free_count;
  logic            locked;
  logic [1:0]      dbg_state;

  park_decrypt_ctrl #(.SLOT_W(SLOT_W), .MAX_FAIL(MAX_FAIL), .LOCK_CYC(LOCK_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .occupancy  (occupancy),
    .free_count (free_count),
    .locked     (locked),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  logic [N-1:0] occ_m;
  int           fail_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popcount(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  // Monitor: compares each response the first cycle it is presented
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (bus.out_valid === 1'b1 && !prev_ov) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got park %0d status %0b, expected none", bus.park_number, bus.status);
      end else begin
        e = exp_q.pop_front();
        check("park_number", 32'(bus.park_number), 32'(e[EW-1 -: SLOT_W]));
        check("status",      32'(bus.status),      32'(e[EW-SLOT_W-1 -: 2]));
        check("occupancy",   32'(occupancy),       32'(e[SLOT_W+N : SLOT_W+1]));
        check("free_count",  32'(free_count),      32'(e[SLOT_W:0]));
      end
    end
    prev_ov <= (bus.out_valid === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic ex, input logic [SLOT_W-1:0] tok, input logic [SLOT_W-1:0] pat);
    logic [SLOT_W-1:0] slot;
    logic [1:0]        st;
    logic [SLOT_W:0]   fc;
    int                k;
    slot = tok ^ pat;
    st   = 2'b00;
    if (!ex) begin
      if (occ_m[slot]) st = 2'b01;
      else             occ_m[slot] = 1'b1;
    end else begin
      if (occ_m[slot]) occ_m[slot] = 1'b0;
      else             st = 2'b10;
    end
    if (st != 2'b00) fail_m = (fail_m < MAX_FAIL) ? fail_m + 1 : MAX_FAIL;
    else             fail_m = 0;
    fc = (SLOT_W+1)'(N - popcount(occ_m));
    exp_q.push_back({slot, st, occ_m, fc});

    k = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.exit     = ex;
    bus.token    = tok;
    bus.pattern  = pat;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic take_resp(input int hold, input bit handshake);
    int k;
    logic [SLOT_W-1:0] pn;
    logic [1:0]        st;
    k = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("resp_timeout", 32'(bus.out_valid), 32'd1);
    pn = bus.park_number;
    st = bus.status;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid),   32'd1);
      check("hold_park",      32'(bus.park_number), 32'(pn));
      check("hold_status",    32'(bus.status),      32'(st));
      check("hold_in_ready",  32'(bus.in_ready),    32'd0);
    end
    if (handshake) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      if (fail_m == MAX_FAIL) fail_m = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lock_cycles;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.exit      = 1'b0;
    bus.token     = '0;
    bus.pattern   = '0;
    occ_m         = '0;
    fail_m        = 0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid",  32'(bus.out_valid),   32'd0);
    check("rst_in_ready",   32'(bus.in_ready),    32'd1);
    check("rst_park",       32'(bus.park_number), 32'd0);
    check("rst_status",     32'(bus.status),      32'd0);
    check("rst_occupancy",  32'(occupancy),       32'd0);
    check("rst_free_count", 32'(free_count),      32'd8);
    check("rst_locked",     32'(locked),          32'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    // Entry to slot 2, then the same entry (slot busy), then exit from free slot 0
    send_req(1'b0, 3'b101, 3'b111); take_resp(0, 1'b1);
    send_req(1'b0, 3'b101, 3'b111); take_resp(0, 1'b1);
    send_req(1'b1, 3'b001, 3'b001); take_resp(0, 1'b1);
    // Third consecutive failure (exit from free slot 1) triggers lockout
    send_req(1'b1, 3'b001, 3'b000); take_resp(0, 1'b1);

    // Keep a request asserted through the whole lockout; none may be taken
    bus.exit     = 1'b0;
    bus.token    = 3'b011;
    bus.pattern  = 3'b000;
    bus.in_valid = 1'b1;
    lock_cycles  = 0;
    for (int i = 0; i < LOCK_CYC; i++) begin
      @(negedge clk);
      if (locked === 1'b1) lock_cycles++;
      check("lock_in_ready", 32'(bus.in_ready), 32'd0);
    end
    check("lock_length", 32'(lock_cycles), 32'(LOCK_CYC));
    @(negedge clk);
    check("unlock_in_ready",  32'(bus.in_ready), 32'd1);
    check("unlock_locked",    32'(locked),       32'd0);
    check("lock_occupancy",   32'(occupancy),    32'h04);
    bus.in_valid = 1'b0;

    // Fill every slot; slot 2 is already occupied and reports busy
    for (int s = 0; s < N; s++) begin
      logic [SLOT_W-1:0] t;
      t = SLOT_W'(s) ^ 3'b110;
      send_req(1'b0, t, 3'b110);
      take_resp(0, 1'b1);
    end
    @(negedge clk);
    check("full_occupancy",  32'(occupancy),  32'hFF);
    check("full_free_count", 32'(free_count), 32'd0);
    send_req(1'b1, 3'b111, 3'b000); take_resp(0, 1'b1);
    @(negedge clk);
    check("exit7_occupancy",  32'(occupancy),  32'h7F);
    check("exit7_free_count", 32'(free_count), 32'd1);

    // Stall the response for 5 cycles, then reset while it is still in RESP
    send_req(1'b0, 3'b000, 3'b000);
    take_resp(5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rstresp_out_valid",  32'(bus.out_valid), 32'd0);
    check("rstresp_occupancy",  32'(occupancy),     32'd0);
    check("rstresp_free_count", 32'(free_count),    32'd8);
    check("rstresp_queue",      32'(exp_q.size()),  32'd0);
    occ_m  = '0;
    fail_m = 0;
    #10;
    @(negedge clk) rst_n = 1'b1;

    // After reset the block serves requests again (entry to slot 5)
    send_req(1'b0, 3'b100, 3'b001); take_resp(0, 1'b1);
    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
